// File: rtl/bytebeat_pkg.sv
// Shared types and constants for the bytebeat sequencer.
package bytebeat_pkg;

  localparam int PCM_W = 8;
  localparam int PRM_W = 16;
  localparam logic [PCM_W-1:0] PCM_RESET = 8'h80;

  // Request/response transaction state.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/bytebeat_tick_div.sv
// Sample-rate divisor: free-running counter that pulses tick once every div+1 enabled cycles.
module bytebeat_tick_div #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] r_count;

  // Compare against the live div so a new divisor applies on the very next compare.
  assign tick = ena && (r_count == div);

  // Count while enabled; wrap on match, and also wrap silently if div shrank below the count.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // flop samples pre-edge values regardless of block evaluation order.
    if (!rst_n) begin
      r_count <= '0;
    end else if (ena) begin
      if (r_count >= div) r_count <= '0;
      else                r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/bytebeat_sequencer.sv
// Bytebeat sequencer: paces requests to an external sample generator and holds its output.
module bytebeat_sequencer
  import bytebeat_pkg::*;
#(
  parameter int T_W   = 24,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [DIV_W-1:0] div,
  input  logic [PRM_W-1:0] prm_in,
  output logic [T_W-1:0]   req_t,
  output logic [PRM_W-1:0] req_prm,
  output logic             req_vld,
  input  logic             req_rdy,
  input  logic [PCM_W-1:0] rsp_pcm,
  input  logic             rsp_vld,
  output logic             rsp_rdy,
  output logic [PCM_W-1:0] pcm,
  output logic             pcm_stb,
  output logic             overrun
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_tick;
  logic             w_capture;
  logic             w_accept;
  logic             w_drop;
  logic [T_W-1:0]   r_t;
  logic [T_W-1:0]   r_req_t;
  logic [PRM_W-1:0] r_req_prm;
  logic [PCM_W-1:0] r_pcm;
  logic             r_pcm_stb;
  logic             r_overrun;

  bytebeat_tick_div #(.DIV_W(DIV_W)) u_tick_div (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .div   (div),
    .tick  (w_tick)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and handshake decode; a tick is only taken while IDLE.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    w_state_nxt = r_state;
    req_vld     = 1'b0;
    rsp_rdy     = 1'b0;
    w_capture   = 1'b0;
    w_accept    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_tick) begin
          w_capture   = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        req_vld = 1'b1;
        if (req_rdy) w_state_nxt = WAIT;
      end
      WAIT: begin
        rsp_rdy = 1'b1;
        if (rsp_vld) begin
          w_accept    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // A tick outside IDLE (including the response-accept cycle) is lost.
  assign w_drop = w_tick && (r_state != IDLE);

  // Request snapshot, sample hold, time index and sticky overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_t       <= '0;
      r_req_t   <= '0;
      r_req_prm <= '0;
      r_pcm     <= PCM_RESET;
      r_pcm_stb <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_pcm_stb <= w_accept;
      if (w_capture) begin
        r_req_t   <= r_t;
        r_req_prm <= prm_in;
      end
      if (w_accept) begin
        r_pcm <= rsp_pcm;
        r_t   <= r_t + 1'b1;
      end
      if (w_drop) r_overrun <= 1'b1;
    end
  end

  assign req_t   = r_req_t;
  assign req_prm = r_req_prm;
  assign pcm     = r_pcm;
  assign pcm_stb = r_pcm_stb;
  assign overrun = r_overrun;

endmodule

// File: doc/bytebeat_sequencer.md
BYTEBEAT_SEQUENCER -- requirements
Module: bytebeat_sequencer

Interface
REQ-001 SHALL have parameter T_W, default 24, time-index width.
REQ-002 SHALL have parameter DIV_W, default 16, sample-rate divisor width.
REQ-003 SHALL have one clock and asynchronous active-low reset: clk  in  1  sole clock, all state on rising edge.
REQ-004 rst_n  in  1  async active-low reset.
REQ-005 ena  in  1  run enable; low freezes divisor counter and blocks new ticks.
REQ-006 div  in  DIV_W  tick period minus one, in clk cycles.
REQ-007 prm_in  in  16  live parameters {d,c,b,a}, 4 bits each.
REQ-008 req_t  out  T_W  time index to generator.
REQ-009 req_prm  out  16  parameter snapshot to generator.
REQ-010 req_vld / req_rdy  out / in  1  request handshake.
REQ-011 rsp_pcm / rsp_vld / rsp_rdy  in / in / out  8,1,1  generator result handshake.
REQ-012 pcm  out  8  held output sample.
REQ-013 pcm_stb  out  1  one-cycle pulse when pcm updates.
REQ-014 overrun  out  1  sticky flag: tick missed.

Function
REQ-015 Divisor counter SHALL count 0..div while ena=1; tick asserts one cycle when count==div, counter returns to 0 next cycle; div=0 gives tick every ena cycle.
REQ-016 Change of div SHALL take effect on the next compare; if count>div, counter SHALL wrap to 0 on next cycle without tick.
REQ-017 FSM states IDLE, ISSUE, WAIT.
REQ-018 IDLE + tick -> ISSUE; same edge SHALL capture prm_in into req_prm and current t into req_t.
REQ-019 ISSUE: req_vld=1, req_t/req_prm stable; req_vld&req_rdy -> WAIT.
REQ-020 WAIT: rsp_rdy=1; rsp_vld&rsp_rdy -> IDLE, pcm<=rsp_pcm, pcm_stb=1 next cycle, t<=t+1 mod 2^T_W.
REQ-021 rsp_rdy SHALL be 0 outside WAIT; req_vld SHALL be 0 outside ISSUE.
REQ-022 Tick while in ISSUE or WAIT SHALL be dropped and set overrun; t SHALL NOT advance for the dropped tick.
REQ-023 Tick in same cycle as response accept SHALL be treated as overrun (FSM not yet IDLE).
REQ-024 overrun SHALL clear only on reset.
REQ-025 ena falling mid-transaction SHALL NOT abort it; transaction completes, no further ticks.
REQ-026 Combinational ready/valid: zero-wait generator (req_rdy, rsp_vld tied high) gives tick-to-pcm_stb latency of 3 cycles (tick->ISSUE, ->WAIT, ->IDLE with pcm update).
REQ-027 pcm SHALL hold between updates; t wraps from 2^T_W-1 to 0 silently.

Reset
REQ-028 Async assert, sync-deassert-safe: state=IDLE, counter=0, t=0, req_t=0, req_prm=0, pcm=8'h80 (mid-scale), pcm_stb=0, overrun=0, req_vld=0, rsp_rdy=0.
REQ-029 Reset mid-transaction SHALL drop it; no pcm_stb.

Structure
REQ-030 Shared package bytebeat_pkg SHALL hold FSM state enum, PCM_W=8, PRM_W=16, PCM_RESET=8'h80.
REQ-031 One sub-module bytebeat_tick_div (divisor counter, tick output) is natural; FSM and registers in top.

Verification
REQ-032 div=3, ena=1, generator always ready, rsp_pcm=t[7:0] -> pcm_stb every 4 cycles, pcm sequence 0,1,2,...; overrun=0.
REQ-033 div=0, generator rsp_vld delayed 5 cycles -> ticks dropped, overrun=1, t increments once per completed transaction only.
REQ-034 prm_in changes while in ISSUE with req_rdy=0 -> req_prm holds snapshot value until handshake.
REQ-035 T_W=4, 17 samples -> req_t sequence 0..15,0; no stall.
REQ-036 rst_n low while in WAIT -> immediate IDLE, pcm=8'h80, rsp_rdy=0, no pcm_stb.
REQ-037 div=10, ena low after 4 cycles for 20 cycles then high -> first tick 7 cycles after ena returns.
